// File: rtl/fetch_align.sv
// Fetch/realign stage: word reads feed a 6-halfword parcel FIFO; one RV32 or RVC instruction per cycle into IF/ID.
// IF/ID loads the cycle after a response is captured; hz holds IF/ID, dbg/mem_hold freeze all but response capture.
module fetch_align #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              dbg,
  input  logic              mem_hold,
  input  logic              hz,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branoff,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ins,
  output logic              comp_sig,
  output logic [ADDR_W-1:0] IF_ID_pres_addr
);

  localparam logic [ADDR_W-1:0] INC2 = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] INC4 = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic [ADDR_W-1:0] pres_q, pres_d;
  logic [31:0]       ins_q, ins_d;
  logic              comp_q, comp_d;
  logic [95:0]       pbuf_q, pbuf_d;
  logic [2:0]        hcnt_q, hcnt_d;
  logic              inflight_q;
  logic              skip_lo_q, skip_lo_d;

  logic              freeze, branch_eff, issue, drop, capture, flush;
  logic              avail32, avail16;
  logic [3:0]        occ, hcnt_sum;
  logic [ADDR_W-1:0] br_word;
  logic [1:0]        pop_n, app_n;
  logic [2:0]        keep;
  logic [31:0]       app_dat, app_mask;
  logic [95:0]       shifted, app_vec, app_vmask;

  always_comb begin
    freeze     = dbg | mem_hold;
    branch_eff = branch & ~hz & ~freeze;
    br_word    = {branoff[ADDR_W-1:2], 2'b00};
    occ        = {1'b0, hcnt_q} + {2'b00, inflight_q, 1'b0};
    issue      = ~freeze & ~branch_eff & (occ <= 4'd4);
    imem_en    = ~Rst & (branch_eff | issue);
    imem_addr  = branch_eff ? br_word : fetch_pc_q;
    // The stale response of a redirected fetch arrives in the redirect cycle itself.
    drop       = branch_eff & inflight_q;
    capture    = inflight_q & ~drop;
    avail32    = (hcnt_q >= 3'd2) && (pbuf_q[1:0] == 2'b11);
    avail16    = (hcnt_q >= 3'd1) && (pbuf_q[1:0] != 2'b11);
  end

  always_comb begin
    ins_d     = ins_q;
    comp_d    = comp_q;
    pres_d    = pres_q;
    head_pc_d = head_pc_q;
    skip_lo_d = skip_lo_q;
    pop_n     = 2'd0;
    flush     = 1'b0;
    app_n     = 2'd0;
    app_dat   = '0;
    app_mask  = '0;

    if (capture) begin
      if (skip_lo_q) begin
        app_n     = 2'd1;
        app_dat   = {16'h0000, imem_rdata[31:16]};
        app_mask  = 32'h0000_FFFF;
        skip_lo_d = 1'b0;
      end else begin
        app_n    = 2'd2;
        app_dat  = imem_rdata;
        app_mask = 32'hFFFF_FFFF;
      end
    end

    if (!freeze) begin
      if (branch_eff) begin
        ins_d     = '0;
        comp_d    = 1'b0;
        flush     = 1'b1;
        skip_lo_d = branoff[1];
        head_pc_d = branoff;
      end else if (!hz) begin
        if (avail32) begin
          ins_d     = pbuf_q[31:0];
          comp_d    = 1'b0;
          pres_d    = head_pc_q;
          pop_n     = 2'd2;
          head_pc_d = head_pc_q + INC4;
        end else if (avail16) begin
          ins_d     = {16'h0000, pbuf_q[15:0]};
          comp_d    = 1'b1;
          pres_d    = head_pc_q;
          pop_n     = 2'd1;
          head_pc_d = head_pc_q + INC2;
        end else begin
          ins_d  = '0;
          comp_d = 1'b0;
        end
      end
    end

    if (branch_eff)  fetch_pc_d = br_word + INC4;
    else if (issue)  fetch_pc_d = fetch_pc_q + INC4;
    else             fetch_pc_d = fetch_pc_q;

    // Pop from the head, then drop new parcels in just above the survivors.
    keep      = hcnt_q - {1'b0, pop_n};
    shifted   = pbuf_q >> {pop_n, 4'b0000};
    app_vec   = {64'h0, app_dat} << {keep, 4'b0000};
    app_vmask = {64'h0, app_mask} << {keep, 4'b0000};
    pbuf_d    = (shifted & ~app_vmask) | app_vec;
    hcnt_sum  = {1'b0, keep} + {2'b00, app_n};
    hcnt_d    = flush ? 3'd0 : hcnt_sum[2:0];
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      fetch_pc_q <= RESET_PC & ~ADDR_W'(3);
      head_pc_q  <= RESET_PC;
      skip_lo_q  <= RESET_PC[1];
      pres_q     <= '0;
      ins_q      <= '0;
      comp_q     <= 1'b0;
      pbuf_q     <= '0;
      hcnt_q     <= 3'd0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      skip_lo_q  <= skip_lo_d;
      pres_q     <= pres_d;
      ins_q      <= ins_d;
      comp_q     <= comp_d;
      pbuf_q     <= pbuf_d;
      hcnt_q     <= hcnt_d;
      inflight_q <= imem_en;
    end
  end

  // The issue throttle guarantees room for every in-flight word.
  always_ff @(posedge clk) begin
    if (!Rst && !flush) assert (hcnt_sum <= 4'd6);
  end

  assign ins             = ins_q;
  assign comp_sig        = comp_q;
  assign IF_ID_pres_addr = pres_q;

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: per-cycle vector table against a word-addressed memory model, plus startup and stall-stream sequences.
module tb_fetch_align;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        dbg = 1'b0;
  logic        mem_hold = 1'b0;
  logic        hz = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branoff = '0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ins;
  logic        comp_sig;
  logic [31:0] IF_ID_pres_addr;

  fetch_align #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .Rst(Rst), .dbg(dbg), .mem_hold(mem_hold), .hz(hz),
    .branch(branch), .branoff(branoff), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .ins(ins), .comp_sig(comp_sig), .IF_ID_pres_addr(IF_ID_pres_addr)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr[11:2]];

  typedef struct {
    logic        rst, hz, mh, dbg, br;
    logic [31:0] boff;
    logic        en;
    logic [31:0] ia, ins, pc;
    logic        comp;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cur_row = -1;

  function automatic logic [31:0] wexp(input logic [31:0] a);
    return (((a >> 2) + 32'd1) << 20) | 32'h13;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (row %0d): got %h, expected %h", nm, cur_row, act, exp);
  endtask

  task automatic vr(input logic r, h, m, d, b, input logic [31:0] bo, input logic e,
                    input logic [31:0] ia, input logic [31:0] in_, input logic c, input logic [31:0] pc);
    vec_t v;
    v.rst = r; v.hz = h; v.mh = m; v.dbg = d; v.br = b; v.boff = bo;
    v.en = e; v.ia = ia; v.ins = in_; v.comp = c; v.pc = pc;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          k;
    int          loads;
    logic [31:0] last_pc;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013;
    for (int i = 0; i < 16; i++) mem[i] = wexp(32'(i * 4));
    mem[16]  = 32'h0013_0001; mem[17]  = 32'h0001_0000; mem[18]  = 32'h00C0_0013; mem[19]  = 32'hDEAD_BEEF;
    mem[64]  = 32'h4505_1111; mem[65]  = 32'h00D0_0013; mem[66]  = 32'h00E0_0013; mem[67]  = 32'hDEAD_BEEF;
    mem[128] = 32'h0093_2222; mem[129] = 32'h1234_0000; mem[130] = 32'h00F0_0013; mem[131] = 32'hDEAD_BEEF;

    //  rst hz mh dbg br boff       en ia         ins           comp pc
    vr(1, 0, 0, 0, 0, 32'h0,    0, 32'h0,   32'h0,          0, 32'h0);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h0,   32'h0,          0, 32'h0);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h4,   32'h0,          0, 32'h0);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h8,   32'h0010_0013,  0, 32'h0);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'hC,   32'h0020_0013,  0, 32'h4);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h10,  32'h0030_0013,  0, 32'h8);
    vr(0, 1, 0, 0, 0, 32'h0,    1, 32'h14,  32'h0030_0013,  0, 32'h8);
    vr(0, 1, 0, 0, 0, 32'h0,    0, 32'h0,   32'h0030_0013,  0, 32'h8);
    vr(0, 1, 0, 0, 0, 32'h0,    0, 32'h0,   32'h0030_0013,  0, 32'h8);
    vr(0, 0, 0, 0, 0, 32'h0,    0, 32'h0,   32'h0040_0013,  0, 32'hC);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h18,  32'h0050_0013,  0, 32'h10);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h1C,  32'h0060_0013,  0, 32'h14);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h20,  32'h0070_0013,  0, 32'h18);
    vr(0, 0, 1, 0, 0, 32'h0,    0, 32'h0,   32'h0070_0013,  0, 32'h18);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h24,  32'h0080_0013,  0, 32'h1C);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h28,  32'h0090_0013,  0, 32'h20);
    vr(0, 0, 0, 1, 1, 32'h40,   0, 32'h0,   32'h0090_0013,  0, 32'h20);
    vr(0, 0, 0, 0, 1, 32'h40,   1, 32'h40,  32'h0,          0, 32'h20);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h44,  32'h0,          0, 32'h20);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h48,  32'h0000_0001,  1, 32'h40);
    vr(0, 0, 0, 0, 0, 32'h0,    0, 32'h0,   32'h0000_0013,  0, 32'h42);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h4C,  32'h0000_0001,  1, 32'h46);
    vr(0, 0, 0, 0, 1, 32'h102,  1, 32'h100, 32'h0,          0, 32'h46);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h104, 32'h0,          0, 32'h46);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h108, 32'h0000_4505,  1, 32'h102);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h10C, 32'h00D0_0013,  0, 32'h104);
    vr(0, 0, 0, 0, 1, 32'h202,  1, 32'h200, 32'h0,          0, 32'h104);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h204, 32'h0,          0, 32'h104);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h208, 32'h0,          0, 32'h104);
    vr(0, 0, 0, 0, 0, 32'h0,    0, 32'h0,   32'h0000_0093,  0, 32'h202);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h20C, 32'h0000_1234,  1, 32'h206);
    vr(1, 0, 0, 0, 1, 32'h40,   0, 32'h0,   32'h0,          0, 32'h0);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h0,   32'h0,          0, 32'h0);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h4,   32'h0,          0, 32'h0);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h8,   32'h0010_0013,  0, 32'h0);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'hC,   32'h0020_0013,  0, 32'h4);
    vr(0, 1, 0, 0, 1, 32'h40,   1, 32'h10,  32'h0020_0013,  0, 32'h4);
    vr(0, 0, 0, 0, 0, 32'h0,    0, 32'h0,   32'h0030_0013,  0, 32'h8);
    vr(0, 0, 0, 0, 0, 32'h0,    1, 32'h14,  32'h0040_0013,  0, 32'hC);

    foreach (tbl[i]) begin
      cur_row = i;
      @(negedge clk);
      Rst = tbl[i].rst; hz = tbl[i].hz; mem_hold = tbl[i].mh; dbg = tbl[i].dbg;
      branch = tbl[i].br; branoff = tbl[i].boff;
      #1;
      check("imem_en", 32'(imem_en), 32'(tbl[i].en));
      if (tbl[i].en) check("imem_addr", imem_addr, tbl[i].ia);
      @(posedge clk);
      #1;
      check("ins", ins, tbl[i].ins);
      check("comp_sig", 32'(comp_sig), 32'(tbl[i].comp));
      check("pres_addr", IF_ID_pres_addr, tbl[i].pc);
    end

    // Start-up latency: first instruction lands on the 3rd edge after the reset edge.
    cur_row = 100;
    @(negedge clk);
    Rst = 1'b1; hz = 1'b0; mem_hold = 1'b0; dbg = 1'b0; branch = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Rst = 1'b0;
    k = 0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (ins != 32'h0) begin
        k = e;
        break;
      end
    end
    check("startup_edges", 32'(k), 32'd3);
    check("startup_ins", ins, 32'h0010_0013);
    check("startup_pc", IF_ID_pres_addr, 32'h0);

    // Stall-riddled stream: every word 0x0..0x3C must appear exactly once, in order.
    cur_row = 200;
    loads = 1;
    last_pc = 32'h0;
    for (int c = 0; c < 60 && last_pc < 32'h3C; c++) begin
      @(negedge clk);
      hz = (c % 5 == 2);
      mem_hold = (c % 7 == 3);
      @(posedge clk);
      #1;
      if (ins != 32'h0 && IF_ID_pres_addr != last_pc && IF_ID_pres_addr < 32'h40) begin
        check("seq_pc", IF_ID_pres_addr, last_pc + 32'd4);
        check("seq_ins", ins, wexp(last_pc + 32'd4));
        last_pc = last_pc + 32'd4;
        loads++;
      end
    end
    check("seq_loads", 32'(loads), 32'd16);

    @(negedge clk);
    hz = 1'b0; mem_hold = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
